// File: rtl/mpadder_iter.sv
// mpadder_iter: limb-serial multi-precision adder/subtractor with start/done.
// Operands are shifted down one step per cycle through a narrow adder while
// the partial sum is shifted in from the top, so no wide limb muxes are needed.
// Optional build macro MPADDER_ITER_CSEL_EN: two limbs per cycle using a
// carry-select upper limb; results are identical, only latency changes.
module mpadder_iter #(
  parameter int WIDTH  = 1027,
  parameter int LIMB_W = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             done,
  output logic             busy
);

  localparam int NLIMB = (WIDTH + LIMB_W - 1) / LIMB_W;
`ifdef MPADDER_ITER_CSEL_EN
  localparam int LPC = 2;
`else
  localparam int LPC = 1;
`endif
  localparam int STEPS  = (NLIMB + LPC - 1) / LPC;
  localparam int STEPW  = LPC * LIMB_W;
  localparam int PADW   = STEPS * STEPW;
  // Bit of the final limb sum that holds the carry out of operand bit WIDTH-1
  localparam int TOPBIT = ((WIDTH - 1) % LIMB_W) + 1;
  localparam int CNTW   = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNTW-1:0] LASTCNT = CNTW'(STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [PADW-1:0]   opA_q, opB_q, sum_q;
  logic [PADW-1:0]   sumNext;
  logic              c_q, sub_q, done_q;
  logic [CNTW-1:0]   cnt_q;
  logic [WIDTH:0]    result_q;
  logic              accept, lastStep;
  logic [LIMB_W:0]   lowSum;
  logic [STEPW-1:0]  stepSum;
  logic              stepCarry, carryTop;

  assign accept   = (state_q == IDLE) && start;
  assign lastStep = (state_q == RUN) && (cnt_q == LASTCNT);

  // Lowest limb of the current step, with the running carry
  assign lowSum = {1'b0, opA_q[LIMB_W-1:0]} + {1'b0, opB_q[LIMB_W-1:0]}
                + {{LIMB_W{1'b0}}, c_q};

`ifdef MPADDER_ITER_CSEL_EN
  logic [LIMB_W:0] upSum0, upSum1, upSel;

  // Upper limb for both carry-ins, picked by the lower limb's carry out
  always_comb begin
    upSum0    = {1'b0, opA_q[STEPW-1:LIMB_W]} + {1'b0, opB_q[STEPW-1:LIMB_W]};
    upSum1    = upSum0 + (LIMB_W+1)'(1);
    upSel     = lowSum[LIMB_W] ? upSum1 : upSum0;
    stepSum   = {upSel[LIMB_W-1:0], lowSum[LIMB_W-1:0]};
    stepCarry = upSel[LIMB_W];
    carryTop  = (NLIMB % 2 == 1) ? lowSum[TOPBIT] : upSel[TOPBIT];
  end
`else
  // One limb per cycle
  always_comb begin
    stepSum   = lowSum[LIMB_W-1:0];
    stepCarry = lowSum[LIMB_W];
    carryTop  = lowSum[TOPBIT];
  end
`endif

  // New step's sum enters at the top while older limbs move down
  assign sumNext = (sum_q >> STEPW) | (PADW'(stepSum) << (PADW - STEPW));

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (lastStep) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy   = (state_q == RUN);
    done   = done_q;
    result = result_q;
  end

  // Control registers: counter, carry, result and done pulse
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q    <= '0;
      c_q      <= 1'b0;
      sub_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        cnt_q <= '0;
        c_q   <= subtract;
        sub_q <= subtract;
      end else if (state_q == RUN) begin
        c_q <= stepCarry;
        if (lastStep) begin
          cnt_q    <= '0;
          result_q <= {carryTop ^ sub_q, sumNext[WIDTH-1:0]};
          done_q   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNTW'(1);
        end
      end
    end
  end

  // Operand and partial-sum shift registers (no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      opA_q <= PADW'(in_a);
      opB_q <= PADW'(in_b ^ {WIDTH{subtract}});
    end else if (state_q == RUN) begin
      opA_q <= opA_q >> STEPW;
      opB_q <= opB_q >> STEPW;
      sum_q <= sumNext;
    end
  end

endmodule

// File: tb/tb_mpadder_iter.sv
// Testbench for mpadder_iter: a default-size instance and a ragged
// WIDTH=10 / LIMB_W=4 instance, directed vectors plus handshake corner cases.
module tb_mpadder_iter;

`ifdef MPADDER_ITER_CSEL_EN
  localparam int BIG_LAT = 9;
  localparam int SM_LAT  = 2;
`else
  localparam int BIG_LAT = 17;
  localparam int SM_LAT  = 3;
`endif

  logic clk = 1'b0;
  logic resetn;
  logic bStart, bSub, bDone, bBusy;
  logic [1026:0] bA, bB;
  logic [1027:0] bRes;
  logic sStart, sSub, sDone, sBusy;
  logic [9:0] sA, sB;
  logic [10:0] sRes;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic [1026:0] a;
    logic [1026:0] b;
    logic          sub;
    logic [1027:0] exp;
    string         name;
  } bigVec_t;

  typedef struct {
    logic [9:0]  a;
    logic [9:0]  b;
    logic        sub;
    logic [10:0] exp;
    string       name;
  } smVec_t;

  bigVec_t bigVecs[8];
  smVec_t  smVecs[7];

  always #5 clk = ~clk;

  mpadder_iter #(.WIDTH(1027), .LIMB_W(64)) dutBig (
    .clk(clk), .resetn(resetn), .start(bStart), .subtract(bSub),
    .in_a(bA), .in_b(bB), .result(bRes), .done(bDone), .busy(bBusy));

  mpadder_iter #(.WIDTH(10), .LIMB_W(4)) dutSmall (
    .clk(clk), .resetn(resetn), .start(sStart), .subtract(sSub),
    .in_a(sA), .in_b(sB), .result(sRes), .done(sDone), .busy(sBusy));

  task automatic checkOutput(input string name, input logic [1027:0] act,
                             input logic [1027:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One operation on the wide instance; caller is #1 after a rising edge
  task automatic applyStimulus(input logic [1026:0] a, input logic [1026:0] b,
                               input logic sub, input logic [1027:0] exp,
                               input string name);
    int cycles = 0;
    int busyCnt;
    bit seen = 0;
    bA = a; bB = b; bSub = sub; bStart = 1'b1;
    @(posedge clk); #1;
    bStart = 1'b0;
    busyCnt = bBusy ? 1 : 0;
    while (!seen && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (bDone) seen = 1;
      else if (bBusy) busyCnt++;
    end
    if (!seen) checkOutput({name, " timeout"}, 1028'd0, 1028'd1);
    else begin
      checkOutput({name, " latency"}, 1028'(cycles), 1028'(BIG_LAT));
      checkOutput({name, " busy cycles"}, 1028'(busyCnt), 1028'(BIG_LAT));
      checkOutput({name, " result"}, bRes, exp);
    end
  endtask

  // One operation on the ragged instance
  task automatic applySmall(input logic [9:0] a, input logic [9:0] b,
                            input logic sub, input logic [10:0] exp,
                            input string name);
    int cycles = 0;
    bit seen = 0;
    sA = a; sB = b; sSub = sub; sStart = 1'b1;
    @(posedge clk); #1;
    sStart = 1'b0;
    while (!seen && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
      if (sDone) seen = 1;
    end
    if (!seen) checkOutput({name, " timeout"}, 1028'd0, 1028'd1);
    else begin
      checkOutput({name, " latency"}, 1028'(cycles), 1028'(SM_LAT));
      checkOutput({name, " result"}, 1028'(sRes), 1028'(exp));
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1055:0] rndA, rndB;
    logic [1026:0] ra, rb;
    logic          rs;
    logic [1027:0] rexp;
    int cycles;
    int doneCnt;
    bit seen;

    bigVecs[0] = '{{1027{1'b1}}, 1027'd1, 1'b0, {1'b1, 1027'b0}, "add max+1"};
    bigVecs[1] = '{1027'd5, 1027'd7, 1'b1, {1'b1, {1026{1'b1}}, 1'b0}, "sub 5-7"};
    bigVecs[2] = '{1027'd7, 1027'd5, 1'b1, 1028'd2, "sub 7-5"};
    bigVecs[3] = '{1027'd0, 1027'd0, 1'b0, 1028'd0, "add 0+0"};
    bigVecs[4] = '{{1027{1'b1}}, {1027{1'b1}}, 1'b0, {1'b1, {1026{1'b1}}, 1'b0}, "add max+max"};
    bigVecs[5] = '{1027'd0, 1027'd1, 1'b1, {1028{1'b1}}, "sub 0-1"};
    bigVecs[6] = '{{963'b0, {64{1'b1}}}, 1027'd1, 1'b0, {963'b0, 1'b1, 64'b0}, "add limb carry"};
    bigVecs[7] = '{{962'b0, 1'b1, 64'b0}, 1027'd1, 1'b1, {964'b0, {64{1'b1}}}, "sub limb borrow"};

    smVecs[0] = '{10'h3FF, 10'h001, 1'b0, 11'h400, "small 3ff+1"};
    smVecs[1] = '{10'h155, 10'h155, 1'b1, 11'h000, "small 155-155"};
    smVecs[2] = '{10'h000, 10'h001, 1'b1, 11'h7FF, "small 0-1"};
    smVecs[3] = '{10'h200, 10'h200, 1'b0, 11'h400, "small 200+200"};
    smVecs[4] = '{10'h0F0, 10'h00F, 1'b0, 11'h0FF, "small f0+f"};
    smVecs[5] = '{10'h3FF, 10'h3FF, 1'b0, 11'h7FE, "small 3ff+3ff"};
    smVecs[6] = '{10'h00F, 10'h0F0, 1'b1, 11'h71F, "small f-f0"};

    resetn = 1'b0;
    bStart = 1'b0; bSub = 1'b0; bA = '0; bB = '0;
    sStart = 1'b0; sSub = 1'b0; sA = '0; sB = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset result", bRes, 1028'd0);
    checkOutput("reset done", 1028'(bDone), 1028'd0);
    checkOutput("reset busy", 1028'(bBusy), 1028'd0);
    checkOutput("reset small result", 1028'(sRes), 1028'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed vectors, wide instance");
    for (int i = 0; i < 8; i++)
      applyStimulus(bigVecs[i].a, bigVecs[i].b, bigVecs[i].sub,
                    bigVecs[i].exp, bigVecs[i].name);

    $display("[TB] directed vectors, ragged instance");
    for (int i = 0; i < 7; i++)
      applySmall(smVecs[i].a, smVecs[i].b, smVecs[i].sub,
                 smVecs[i].exp, smVecs[i].name);

    // Start ignored while busy, result held during RUN, back-to-back start
    $display("[TB] start during busy and back-to-back");
    applyStimulus(1027'd10, 1027'd20, 1'b0, 1028'd30, "pre 10+20");
    bA = 1027'd7; bB = 1027'd5; bSub = 1'b1; bStart = 1'b1;
    @(posedge clk); #1;
    bStart = 1'b0;
    cycles = 0; seen = 0;
    while (!seen && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 4) begin
        bA = 1027'd1; bB = 1027'd1; bSub = 1'b0; bStart = 1'b1;
      end
      if (cycles == 5) begin
        bStart = 1'b0;
        checkOutput("hold during run", bRes, 1028'd30);
      end
      if (bDone) seen = 1;
    end
    checkOutput("busy start latency", 1028'(cycles), 1028'(BIG_LAT));
    checkOutput("busy start result", bRes, 1028'd2);
    bA = 1027'd3; bB = 1027'd4; bSub = 1'b0; bStart = 1'b1;
    @(posedge clk); #1;
    bStart = 1'b0;
    cycles = 0; seen = 0;
    while (!seen && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles == 2) checkOutput("hold b2b", bRes, 1028'd2);
      if (bDone) seen = 1;
    end
    checkOutput("b2b latency", 1028'(cycles), 1028'(BIG_LAT));
    checkOutput("b2b result", bRes, 1028'd7);

    // Reset in the middle of an operation
    $display("[TB] reset mid-operation");
    bA = 1027'd100; bB = 1027'd1; bSub = 1'b0; bStart = 1'b1;
    @(posedge clk); #1;
    bStart = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset result", bRes, 1028'd0);
    checkOutput("midreset busy", 1028'(bBusy), 1028'd0);
    checkOutput("midreset done", 1028'(bDone), 1028'd0);
    resetn = 1'b1;
    doneCnt = 0;
    repeat (2 * BIG_LAT) begin
      @(posedge clk); #1;
      if (bDone) doneCnt++;
    end
    checkOutput("no done after abort", 1028'(doneCnt), 1028'd0);
    applyStimulus(1027'd100, 1027'd1, 1'b0, 1028'd101, "after reset");

    // A few random operations against a plain arithmetic reference
    $display("[TB] random operations");
    for (int i = 0; i < 6; i++) begin
      for (int w = 0; w < 33; w++) begin
        rndA[w*32 +: 32] = $urandom;
        rndB[w*32 +: 32] = $urandom;
      end
      ra = rndA[1026:0];
      rb = rndB[1026:0];
      rs = i[0];
      if (rs) rexp = {(ra < rb), ra - rb};
      else    rexp = {1'b0, ra} + {1'b0, rb};
      applyStimulus(ra, rb, rs, rexp, $sformatf("random %0d", i));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mpadder_iter.md
# mpadder_iter

Parametrised, limb-serial multi-precision adder/subtractor with a start/done handshake, the next generation of the wide-operand adder in the Montgomery datapath. It consumes WIDTH-bit operands one LIMB_W-bit limb per cycle through a single narrow adder, trading latency for area. It returns a WIDTH+1-bit result whose MSB is the carry (add) or the borrow flag (subtract). It sits between the operand registers and the modular-multiply/reduce controller.

## Interface
- WIDTH, 1027: operand width in bits, ≥ 2.
- LIMB_W, 64: limb width in bits, 1 ≤ LIMB_W ≤ WIDTH. NLIMB = ceil(WIDTH/LIMB_W).
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only when not busy.
- subtract  in  1  0 = A+B, 1 = A−B; sampled with start.
- in_a  in  WIDTH  operand A; sampled with start.
- in_b  in  WIDTH  operand B; sampled with start.
- result  out  WIDTH+1  registered result; updated only on the done edge.
- done  out  1  one-cycle pulse; result is valid from this cycle on.
- busy  out  1  high while limbs are being processed.

## Operation
- States: IDLE and RUN. Limb counter cnt runs 0..NLIMB−1. Internal registers: opA, opB, the accumulating sum register, and carry c.
- Accept, at an edge in IDLE with start=1:
  - opA ← in_a.
  - opB ← in_b XOR {WIDTH{subtract}}, with inversion over WIDTH bits only.
  - c ← subtract, cnt ← 0, sub_q ← subtract, state → RUN.
- Zero-extension: both opA and opB are zero-extended to NLIMB·LIMB_W bits after the inversion, so pad bits are 0.
- RUN, per edge: {c, sum limb[cnt]} ← opA limb[cnt] + opB limb[cnt] + c, then cnt++.
- Last limb (cnt = NLIMB−1), on the same edge:
  - result[WIDTH−1:0] ← sum[WIDTH−1:0].
  - result[WIDTH] ← carry out of bit WIDTH−1, XOR sub_q.
  - done ← 1 and state → IDLE.
- Carry out of bit WIDTH−1: when WIDTH is not a multiple of LIMB_W, this is bit (WIDTH−1)%LIMB_W+1 of the final limb sum, not c.
- Arithmetic:
  - add: result = A+B exactly.
  - subtract: result[WIDTH−1:0] = (A−B) mod 2^WIDTH, and result[WIDTH] = 1 iff A < B.
- busy = (state == RUN). start, subtract, in_a and in_b are ignored while busy.
- Reset (resetn=0 at an edge) overrides everything, including mid-RUN. It forces state IDLE, cnt 0, c 0, result 0, done 0 and busy 0. An aborted operation produces no done.

## Timing
- Reset values: result = 0, done = 0, busy = 0.
- Start accepted at edge E0:
  - busy is high after edges E0..E(NLIMB−1).
  - done is high for exactly the one cycle after edge E_NLIMB.
  - Latency: NLIMB cycles. Defaults give 17.
- Back-to-back: in the done cycle the FSM is already IDLE, so start=1 there is accepted. The next done follows NLIMB cycles later. Throughput is one operation per NLIMB cycles.
- result holds its value from the done edge until the next done edge, unchanged during RUN.
- start held high continuously re-launches immediately after each done, sampling the new inputs.

## Configuration
- MPADDER_ITER_CSEL_EN:
  - Defined: two limbs are processed per cycle. The upper limb is computed for both carry-in 0 and 1 in parallel and selected by the lower limb's carry-out (carry-select).
  - Latency is ceil(NLIMB/2) cycles; defaults give 9. If NLIMB is odd, the last cycle processes the single final limb.
  - Undefined: one limb per cycle as described above.
  - Results are identical bit-for-bit in both builds; only latency and busy length change.

## Test plan
- Add, defaults: A = 2^1027−1, B = 1, start one cycle → done 17 cycles later, result = 2^1027, busy high for 17 cycles.
- Subtract with borrow: A = 5, B = 7 → result[1026:0] = 2^1027−2, result[1027] = 1. Subtract A = 7, B = 5 → result = 2, MSB = 0.
- Ragged top limb, WIDTH=10, LIMB_W=4: A = 0x3FF, B = 0x001, add → result = 0x400. Subtract A = B = 0x155 → result = 0.
- Start during busy: second start with different operands at cycle 5 of RUN → ignored, and the first result appears at cycle 17 unchanged. Start in the done cycle → second done exactly 17 cycles later.
- Reset mid-operation: resetn low at cycle 8 of RUN → next cycle result = 0, busy = 0, and no done pulse until a new start.
- Random regression: 10k random (A, B, subtract) against a reference model, run with and without MPADDER_ITER_CSEL_EN. Check latency of 17 vs 9 cycles and identical results.
